mem_io_ctrl: RTL and testbench
==============================

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, data width; ADDR_W, default 20, SRAM address width; WAIT_STATES, default 2, SRAM access cycles (legal range 1..15); NUM_HEX, default 4, hex display nibbles; IO_ADDR, default 'hFFFF, memory-mapped I/O address.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk  in  1  single clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  CPU access request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  CPU address; sampled with req.
- wdata  in  DATA_W  CPU write data; sampled with req.
- rdata  out  DATA_W  read result.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high in every state other than IDLE.
- Switches  in  DATA_W  asynchronous board switches.
- hex_out  out  4*NUM_HEX  hex display register.
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, all active-low.
- ADDR  out  ADDR_W  SRAM address.
- Data_write  out  DATA_W  data to the tristate buffer.
- Data_read  in  DATA_W  data from the tristate buffer.
- data_oe  out  1  tristate drive enable.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and DONE.
REQ-004 In IDLE with req=1 and addr != IO_ADDR, the FSM SHALL latch addr, we and wdata and then go to SETUP.
REQ-005 In IDLE with req=1 and addr == IO_ADDR, the FSM SHALL go directly to DONE, with no SRAM strobe asserted.
REQ-006 I/O write: hex_out SHALL be loaded with wdata[4*NUM_HEX-1:0] on the same edge that enters DONE.
REQ-007 I/O read: rdata SHALL be loaded with the synchronised Switches value on the same edge that enters DONE.
REQ-008 Switches SHALL pass through a 2-flop synchroniser before use.
REQ-009 SETUP SHALL last 1 cycle and load the wait counter with WAIT_STATES-1.
REQ-010 ACCESS SHALL decrement the counter each cycle and go to DONE when the counter is 0, so ACCESS lasts exactly WAIT_STATES cycles.
REQ-011 During SETUP and ACCESS: CE=0, UB=0, LB=0, and ADDR SHALL hold the latched address.
REQ-012 Read strobes: OE=0 in SETUP and ACCESS; WE=1 throughout the read.
REQ-013 Read capture: rdata SHALL load Data_read on the final ACCESS cycle edge.
REQ-014 Write strobes: data_oe=1 in SETUP and ACCESS; WE=0 in ACCESS only; OE=1 throughout the write.
REQ-015 Data_write SHALL equal the latched wdata.
REQ-016 In DONE, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-017 In IDLE and DONE, all strobes SHALL be high and data_oe SHALL be 0.
REQ-018 req asserted while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-019 A new request SHALL be accepted no earlier than the IDLE cycle following DONE.
REQ-020 rdata SHALL hold its value until the next read completes; writes SHALL not alter rdata.
REQ-021 SRAM latency: req sampled at edge t SHALL give ready=1 in cycle t+WAIT_STATES+2.
REQ-022 I/O latency: req sampled at edge t SHALL give ready=1 in cycle t+1.
REQ-023 The WE=0 and OE=0 strobes SHALL never be asserted in the same cycle.
REQ-024 All outputs SHALL be driven from registers or from decode of the state register only, with no combinational path from req.

Reset
REQ-025 On Reset=0 the block SHALL, asynchronously and at any point: enter IDLE; set CE/OE/WE/UB/LB=1; set data_oe=0, ready=0, busy=0, rdata=0, hex_out=0 and ADDR=0; clear the synchroniser flops and the counter.
REQ-026 Reset asserted during SETUP or ACCESS SHALL abort the access, with WE high in the same cycle and no ready pulse.
REQ-027 After Reset is released, the first rising edge SHALL be able to accept a req.

Verification
REQ-028 SRAM read, WAIT_STATES=2, addr=0x00010, Data_read=0xBEEF: OE low for 3 cycles, ready 4 cycles after the req edge, rdata=0xBEEF.
REQ-029 SRAM write, addr=0x00020, wdata=0x1234: WE low for exactly 2 cycles inside a 3-cycle data_oe window; Data_write=0x1234; OE stays high.
REQ-030 I/O write with wdata=0xA5C3, then I/O read with Switches=0x00F0 (stable for 3 or more cycles): hex_out=0xA5C3 and ready after 1 cycle; then rdata=0x00F0, and SRAM CE is never low.
REQ-031 A second req pulse during ACCESS of a read SHALL produce exactly one ready pulse, with the second req dropped.
REQ-032 Reset low mid-write, during the first ACCESS cycle: WE returns high asynchronously, busy=0, no ready pulse; hex_out=0.
REQ-033 WAIT_STATES=1 build, back-to-back reads at 0x1 and 0x2: each ready arrives 3 cycles after its req edge; the second req is accepted in the IDLE cycle after DONE.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// Routes CPU requests to an async SRAM (SETUP, then WAIT_STATES ACCESS cycles, then DONE)
// or, for IO_ADDR, to a switch-input / hex-display register (straight to DONE).
module mem_io_ctrl #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter int                WAIT_STATES = 2,
  parameter int                NUM_HEX     = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 'hFFFF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   busy,
  input  logic [DATA_W-1:0]      Switches,
  output logic [4*NUM_HEX-1:0]   hex_out,
  output logic                   CE,
  output logic                   OE,
  output logic                   WE,
  output logic                   UB,
  output logic                   LB,
  output logic [ADDR_W-1:0]      ADDR,
  output logic [DATA_W-1:0]      Data_write,
  input  logic [DATA_W-1:0]      Data_read,
  output logic                   data_oe
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata;
  logic [4*NUM_HEX-1:0]   r_hex;
  logic [DATA_W-1:0]      r_sw_meta;
  logic [DATA_W-1:0]      r_sw_sync;
  logic                   r_ce;
  logic                   r_oe;
  logic                   r_we_n;
  logic                   r_bs;
  logic                   r_doe;
  logic                   w_io_hit;

  assign w_io_hit = (addr == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= Switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Strobes are registered alongside the state so they change only on state edges.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hex   <= '0;
      r_ce    <= 1'b1;
      r_oe    <= 1'b1;
      r_we_n  <= 1'b1;
      r_bs    <= 1'b1;
      r_doe   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            if (w_io_hit) begin
              r_state <= DONE;
              if (we) r_hex   <= wdata[4*NUM_HEX-1:0];
              else    r_rdata <= r_sw_sync;
            end else begin
              r_state <= SETUP;
              r_addr  <= addr;
              r_we    <= we;
              r_wdata <= wdata;
              r_ce    <= 1'b0;
              r_bs    <= 1'b0;
              r_oe    <= we;
              r_doe   <= we;
            end
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= 4'(WAIT_STATES - 1);
          r_we_n  <= ~r_we;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we_n  <= 1'b1;
            r_bs    <= 1'b1;
            r_doe   <= 1'b0;
            if (!r_we) r_rdata <= Data_read;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready      = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign rdata      = r_rdata;
  assign hex_out    = r_hex;
  assign CE         = r_ce;
  assign OE         = r_oe;
  assign WE         = r_we_n;
  assign UB         = r_bs;
  assign LB         = r_bs;
  assign ADDR       = r_addr;
  assign Data_write = r_wdata;
  assign data_oe    = r_doe;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench: SRAM read/write timing, memory-mapped I/O, dropped requests,
// asynchronous reset abort and WAIT_STATES=1 back-to-back reads.
module tb_mem_io_ctrl;
  logic        Clk = 1'b0;
  logic        Reset, req, req2, we;
  logic [19:0] addr;
  logic [15:0] wdata, Switches, Data_read;

  logic [15:0] rdata, hex_out, Data_write;
  logic        ready, busy, CE, OE, WE, UB, LB, data_oe;
  logic [19:0] ADDR;

  logic [15:0] rdata2, hex_out2, Data_write2;
  logic        ready2, busy2, CE2, OE2, WE2, UB2, LB2, data_oe2;
  logic [19:0] ADDR2;

  int checks = 0;
  int failures = 0;

  int m_kready, m_rdy_cnt, m_oe_low, m_we_low, m_doe_hi, m_ce_low;
  int m_both_low, m_dw_bad, m_adr_bad, m_we_no_doe, m_bs_bad;

  always #5 Clk = ~Clk;

  mem_io_ctrl u_dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .Switches(Switches), .hex_out(hex_out),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR),
    .Data_write(Data_write), .Data_read(Data_read), .data_oe(data_oe)
  );

  mem_io_ctrl #(.WAIT_STATES(1)) u_dut_ws1 (
    .Clk(Clk), .Reset(Reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .busy(busy2), .Switches(Switches), .hex_out(hex_out2),
    .CE(CE2), .OE(OE2), .WE(WE2), .UB(UB2), .LB(LB2), .ADDR(ADDR2),
    .Data_write(Data_write2), .Data_read(Data_read), .data_oe(data_oe2)
  );

  // Issues one request on u_dut and records strobe activity for n samples,
  // sample 1 being the one just after the edge that takes the request.
  task automatic run_access(input logic w, input logic [19:0] a, input logic [15:0] d,
                            input int n, input int extra_at);
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge Clk); #1;
    m_kready = 0; m_rdy_cnt = 0; m_oe_low = 0; m_we_low = 0; m_doe_hi = 0; m_ce_low = 0;
    m_both_low = 0; m_dw_bad = 0; m_adr_bad = 0; m_we_no_doe = 0; m_bs_bad = 0;
    for (int k = 1; k <= n; k++) begin
      req = (k == extra_at);
      if (ready) begin
        m_rdy_cnt++;
        if (m_kready == 0) m_kready = k;
      end
      if (!OE) m_oe_low++;
      if (!WE) m_we_low++;
      if (data_oe) m_doe_hi++;
      if (!CE) m_ce_low++;
      if (!OE && !WE) m_both_low++;
      if (data_oe && Data_write !== d) m_dw_bad++;
      if (!CE && ADDR !== a) m_adr_bad++;
      if (!CE && (UB || LB)) m_bs_bad++;
      if (!WE && !data_oe) m_we_no_doe++;
      @(posedge Clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    Switches = '0; Data_read = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if ({CE, OE, WE, UB, LB} !== 5'b11111) begin failures++; $display("FAIL reset_strobes got=%b exp=11111", {CE, OE, WE, UB, LB}); end
    checks++; if ({data_oe, ready, busy} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {data_oe, ready, busy}); end
    checks++; if (rdata !== 16'h0 || hex_out !== 16'h0 || ADDR !== 20'h0) begin failures++; $display("FAIL reset_regs rdata=%h hex=%h addr=%h exp=0", rdata, hex_out, ADDR); end
    Reset = 1'b1;
  endtask

  task automatic test_sram_read();
    Data_read = 16'hBEEF;
    run_access(1'b0, 20'h00010, 16'h0000, 8, 0);
    checks++; if (m_kready !== 4) begin failures++; $display("FAIL rd_latency got=%0d exp=4", m_kready); end
    checks++; if (m_oe_low !== 3) begin failures++; $display("FAIL rd_oe_low got=%0d exp=3", m_oe_low); end
    checks++; if (m_we_low !== 0 || m_doe_hi !== 0) begin failures++; $display("FAIL rd_we_doe we_low=%0d doe=%0d exp=0/0", m_we_low, m_doe_hi); end
    checks++; if (m_ce_low !== 3 || m_adr_bad !== 0 || m_bs_bad !== 0) begin failures++; $display("FAIL rd_ce_addr ce_low=%0d adr_bad=%0d bs_bad=%0d exp=3/0/0", m_ce_low, m_adr_bad, m_bs_bad); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", rdata); end
    checks++; if (m_rdy_cnt !== 1) begin failures++; $display("FAIL rd_ready_pulses got=%0d exp=1", m_rdy_cnt); end
  endtask

  task automatic test_sram_write();
    Data_read = 16'h7777;
    run_access(1'b1, 20'h00020, 16'h1234, 8, 0);
    checks++; if (m_we_low !== 2) begin failures++; $display("FAIL wr_we_low got=%0d exp=2", m_we_low); end
    checks++; if (m_doe_hi !== 3) begin failures++; $display("FAIL wr_doe got=%0d exp=3", m_doe_hi); end
    checks++; if (m_oe_low !== 0 || m_both_low !== 0 || m_we_no_doe !== 0) begin failures++; $display("FAIL wr_oe oe_low=%0d both=%0d we_no_doe=%0d exp=0/0/0", m_oe_low, m_both_low, m_we_no_doe); end
    checks++; if (m_dw_bad !== 0 || Data_write !== 16'h1234) begin failures++; $display("FAIL wr_data bad=%0d dw=%h exp=0/1234", m_dw_bad, Data_write); end
    checks++; if (m_kready !== 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", m_kready); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL wr_keeps_rdata got=%h exp=beef", rdata); end
  endtask

  task automatic test_io();
    Switches = 16'h00F0;
    repeat (3) @(posedge Clk);
    #1;
    run_access(1'b1, 20'hFFFF, 16'hA5C3, 4, 0);
    checks++; if (m_kready !== 1) begin failures++; $display("FAIL io_wr_latency got=%0d exp=1", m_kready); end
    checks++; if (hex_out !== 16'hA5C3) begin failures++; $display("FAIL io_wr_hex got=%h exp=a5c3", hex_out); end
    checks++; if (m_ce_low !== 0 || m_doe_hi !== 0) begin failures++; $display("FAIL io_wr_strobes ce_low=%0d doe=%0d exp=0/0", m_ce_low, m_doe_hi); end
    run_access(1'b0, 20'hFFFF, 16'h0000, 4, 0);
    checks++; if (m_kready !== 1) begin failures++; $display("FAIL io_rd_latency got=%0d exp=1", m_kready); end
    checks++; if (rdata !== 16'h00F0) begin failures++; $display("FAIL io_rd_data got=%h exp=00f0", rdata); end
    checks++; if (m_ce_low !== 0 || m_oe_low !== 0) begin failures++; $display("FAIL io_rd_strobes ce_low=%0d oe_low=%0d exp=0/0", m_ce_low, m_oe_low); end
  endtask

  task automatic test_dropped_req();
    Data_read = 16'h5A5A;
    run_access(1'b0, 20'h00030, 16'h0000, 12, 3);
    checks++; if (m_rdy_cnt !== 1) begin failures++; $display("FAIL drop_ready_pulses got=%0d exp=1", m_rdy_cnt); end
    checks++; if (m_oe_low !== 3) begin failures++; $display("FAIL drop_oe_low got=%0d exp=3", m_oe_low); end
    checks++; if (rdata !== 16'h5A5A || busy !== 1'b0) begin failures++; $display("FAIL drop_end rdata=%h busy=%b exp=5a5a/0", rdata, busy); end
  endtask

  task automatic test_reset_mid_write();
    int rdy_seen;
    rdy_seen = 0;
    we = 1'b1; addr = 20'h00040; wdata = 16'hCAFE; req = 1'b1;
    @(posedge Clk); #1;
    req = 1'b0;
    @(posedge Clk); #1;
    checks++; if (WE !== 1'b0) begin failures++; $display("FAIL rst_pre_we got=%b exp=0", WE); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (WE !== 1'b1 || busy !== 1'b0 || data_oe !== 1'b0) begin failures++; $display("FAIL rst_abort we=%b busy=%b doe=%b exp=1/0/0", WE, busy, data_oe); end
    checks++; if (hex_out !== 16'h0 || ready !== 1'b0) begin failures++; $display("FAIL rst_abort_regs hex=%h ready=%b exp=0/0", hex_out, ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      if (ready) rdy_seen++;
    end
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (ready) rdy_seen++;
      @(posedge Clk); #1;
    end
    checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL rst_no_ready got=%0d exp=0", rdy_seen); end
  endtask

  task automatic test_first_edge_after_reset();
    Reset = 1'b0;
    #10;
    Reset = 1'b1;
    run_access(1'b1, 20'hFFFF, 16'h0F0F, 3, 0);
    checks++; if (m_kready !== 1 || hex_out !== 16'h0F0F) begin failures++; $display("FAIL post_rst_accept k=%0d hex=%h exp=1/0f0f", m_kready, hex_out); end
  endtask

  task automatic test_back_to_back();
    int k1, k2, pulses;
    logic busy_s4;
    logic [19:0] addr_s5;
    logic [15:0] rd_s3;
    k1 = 0; k2 = 0; pulses = 0; busy_s4 = 1'b1; addr_s5 = '0; rd_s3 = '0;
    we = 1'b0; addr = 20'h00001; Data_read = 16'h1111; req2 = 1'b1;
    @(posedge Clk); #1;
    for (int k = 1; k <= 10; k++) begin
      if (ready2) begin
        pulses++;
        if (k1 == 0) k1 = k; else if (k2 == 0) k2 = k;
      end
      if (k == 1) addr = 20'h00002;
      if (k == 3) begin rd_s3 = rdata2; Data_read = 16'h2222; end
      if (k == 4) busy_s4 = busy2;
      if (k == 5) begin addr_s5 = ADDR2; req2 = 1'b0; end
      @(posedge Clk); #1;
    end
    checks++; if (k1 !== 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=3", k1); end
    checks++; if (rd_s3 !== 16'h1111) begin failures++; $display("FAIL b2b_first_data got=%h exp=1111", rd_s3); end
    checks++; if (busy_s4 !== 1'b0) begin failures++; $display("FAIL b2b_idle_after_done busy=%b exp=0", busy_s4); end
    checks++; if (k2 - 4 !== 3) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=3", k2 - 4); end
    checks++; if (addr_s5 !== 20'h00002 || rdata2 !== 16'h2222) begin failures++; $display("FAIL b2b_second addr=%h rdata=%h exp=00002/2222", addr_s5, rdata2); end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_dropped_req();
    test_reset_mid_write();
    test_first_edge_after_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
